// File: rtl/dvp_tx_generator.sv
// ---------------------------------------------------------------------------
// dvp_tx_generator
// Camera-side DVP transmitter. Takes an RGB565 pixel stream (valid/ready)
// and produces DVP timing (PCLK, VSYNC, HREF, HSYNC, D) with the high byte
// of each pixel sent first. Used as an on-chip camera emulator and as a
// loopback source for the DVP receive path.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   tx_en_i       in   enable frame generation (sampled at frame boundaries)
//   pxl_i         in   RGB565 pixel
//   pxl_vld_i     in   pixel valid
//   pxl_rdy_o     out  pixel ready, one clk wide, once per active pixel slot
//   dvp_pclk_o    out  pixel clock, clk / PCLK_DIV, 50% duty
//   dvp_d_o       out  pixel byte, 0 outside HREF
//   dvp_href_o    out  line-active qualifier
//   dvp_vsync_o   out  frame sync, active high
//   dvp_hsync_o   out  high during the horizontal blanking ticks of each line
//   frame_done_o  out  one-clk pulse on the last blanking tick of the frame
//   underrun_o    out  sticky: a pixel was missing in an active slot
//   busy_o        out  high whenever the generator is not idle
// ---------------------------------------------------------------------------
module dvp_tx_generator #(
  parameter int DVP_DATA_W  = 8,
  parameter int RGB_PXL_W   = 16,
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int HBLANK      = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10,
  parameter int PCLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en_i,
  input  logic [RGB_PXL_W-1:0]  pxl_i,
  input  logic                  pxl_vld_i,
  output logic                  pxl_rdy_o,
  output logic                  dvp_pclk_o,
  output logic [DVP_DATA_W-1:0] dvp_d_o,
  output logic                  dvp_href_o,
  output logic                  dvp_vsync_o,
  output logic                  dvp_hsync_o,
  output logic                  frame_done_o,
  output logic                  underrun_o,
  output logic                  busy_o
);

  localparam int ACT_BYTES = 2 * FRAME_W;
  localparam int LINE      = ACT_BYTES + HBLANK;
  localparam int COL_W     = $clog2(LINE);
  localparam int MAX_A     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int MAX_B     = (FRAME_H > VFP_LINES) ? FRAME_H : VFP_LINES;
  localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LN_W      = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam int DIV_W     = $clog2(PCLK_DIV);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE - 1);
  localparam logic [COL_W-1:0] ACT_END  = COL_W'(ACT_BYTES);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [LN_W-1:0]  LN_ONE   = LN_W'(1);
  localparam logic [LN_W-1:0]  VFP_LAST = LN_W'(VFP_LINES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PCLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [LN_W-1:0]         line_q, line_d, line_last;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    pclk_q, pclk_d;
  logic                    href_q, href_d;
  logic                    vsync_q, vsync_d;
  logic                    hsync_q, hsync_d;
  logic [DVP_DATA_W-1:0]   d_q, d_d;
  logic [DVP_DATA_W-1:0]   lo_q, lo_d;
  logic                    done_q, done_d;
  logic                    under_q, under_d;
  logic                    tick;
  logic                    slot_href;

  // Pixel clock divider: free running in every state. The tick is the last
  // divider count, so registered DVP outputs change together with the PCLK
  // falling edge and are stable at the following rising edge.
  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + DIV_ONE;
    pclk_d = (div_d >= DIV_HALF);
  end

  // State register (also holds all output registers)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      div_q   <= '0;
      pclk_q  <= 1'b0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      d_q     <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      href_q  <= href_d;
      vsync_q <= vsync_d;
      hsync_q <= hsync_d;
      d_q     <= d_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

  // Next-state logic. state/col/line describe the slot currently on the
  // DVP pins; on a tick they advance to the slot being launched.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    case (state_q)
      S_VSYNC:  line_last = LN_W'(VSYNC_LINES - 1);
      S_VBP:    line_last = LN_W'(VBP_LINES - 1);
      S_ACTIVE: line_last = LN_W'(FRAME_H - 1);
      S_VFP:    line_last = VFP_LAST;
      default:  line_last = '0;
    endcase
    if (tick) begin
      if (state_q == S_IDLE) begin
        if (tx_en_i) begin
          state_d = S_VSYNC;
          col_d   = '0;
          line_d  = '0;
        end
      end else if (col_q != COL_LAST) begin
        col_d = col_q + COL_ONE;
      end else begin
        col_d = '0;
        if (line_q != line_last) begin
          line_d = line_q + LN_ONE;
        end else begin
          line_d = '0;
          case (state_q)
            S_VSYNC:  state_d = (VBP_LINES > 0) ? S_VBP : S_ACTIVE;
            S_VBP:    state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFP;
            S_VFP:    state_d = tx_en_i ? S_VSYNC : S_IDLE;
            default:  state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  // Output logic. Everything is launched from the slot being entered, so
  // the first VSYNC slot appears on the same tick that leaves IDLE.
  always_comb begin
    slot_href = (state_d == S_ACTIVE) && (col_d < ACT_END);
    pxl_rdy_o = tick && slot_href && !col_d[0];
    href_d    = href_q;
    vsync_d   = vsync_q;
    hsync_d   = hsync_q;
    d_d       = d_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    under_d   = under_q;
    if (tick) begin
      href_d  = slot_href;
      vsync_d = (state_d == S_VSYNC);
      hsync_d = (state_d != S_IDLE) && (col_d >= ACT_END);
      done_d  = (state_d == S_VFP) && (col_d == COL_LAST) && (line_d == VFP_LAST);
      if (state_d == S_VSYNC && state_q != S_VSYNC) under_d = 1'b0;
      if (!slot_href) begin
        d_d = '0;
      end else if (!col_d[0]) begin
        // Even slot: the pixel handshake happens now; a missing pixel is
        // replaced by zeros for both of its bytes.
        if (pxl_vld_i) begin
          {d_d, lo_d} = pxl_i;
        end else begin
          d_d     = '0;
          lo_d    = '0;
          under_d = 1'b1;
        end
      end else begin
        d_d = lo_q;
      end
    end
  end

  assign dvp_pclk_o   = pclk_q;
  assign dvp_d_o      = d_q;
  assign dvp_href_o   = href_q;
  assign dvp_vsync_o  = vsync_q;
  assign dvp_hsync_o  = hsync_q;
  assign frame_done_o = done_q;
  assign underrun_o   = under_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
